vertex_hist_sched: RTL and testbench
====================================

Name: vertex_hist_sched

Overview:
- Event scheduler in front of the vertex histogram block. It shares one histogram engine between N_SRC track-set sources on a per-event basis.
- Round-robin grant per event. Before each event it pulses a histogram clear, then streams exactly SETS_PER_EVENT track sets through a registered output stage with valid/ready handshake.
- After the last set it waits for the histogram's completion pulse before granting the next event.

Parameters:
- N_SRC, 4, number of track-set sources (2..8).
- TRACKS_IN_SET, 18, track words per set.
- TRACK_W, 96, bits per track word.
- SETS_PER_EVENT, 54, sets per event (1..127).
- CNT_W, 7, set counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- src_set_in  in  N_SRC*TRACKS_IN_SET*TRACK_W  flattened track sets; source s at [s*TRACKS_IN_SET*TRACK_W +: TRACKS_IN_SET*TRACK_W].
- src_vld_in  in  N_SRC  per-source valid.
- src_rdy_out  out  N_SRC  per-source ready.
- hist_set_out  out  TRACKS_IN_SET*TRACK_W  registered set to histogram.
- hist_vld_out  out  1  valid to histogram.
- hist_rdy_in  in  1  ready from histogram.
- hist_clr_out  out  1  one-cycle histogram clear.
- hist_done_in  in  1  histogram completion pulse.
- set_cnt_out  out  CNT_W  index of the set in hist_set_out.
- sop_out  out  1  first set of event, qualified by hist_vld_out.
- eop_out  out  1  last set of event, qualified by hist_vld_out.
- grant_out  out  N_SRC  one-hot grant; 0 in IDLE.
- evt_cnt_out  out  16  completed events, wraps at 2^16.
- busy_out  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release) sets every output to 0, state to IDLE, round-robin pointer to N_SRC-1 and internal set counter to 0.
- FSM states: IDLE, CLR, STREAM, WAIT_DONE.
- IDLE: if any src_vld_in is high, grant the first requester searching from pointer+1 upward, with modulo wrap. Register grant_out, go to CLR. If no source is valid, stay in IDLE.
- CLR: hist_clr_out=1 for exactly this one cycle; all src_rdy_out=0. Next state is STREAM.
- STREAM:
  - Only the granted source sees ready: src_rdy_out[g] = (!hist_vld_out || hist_rdy_in) && (acc_cnt < SETS_PER_EVENT). All other bits are 0.
  - A source transfer occurs when src_vld_in[g] && src_rdy_out[g]. On a transfer the set is loaded into hist_set_out, hist_vld_out goes to 1 next cycle (latency 1), set_cnt_out=acc_cnt, sop_out=(acc_cnt==0), eop_out=(acc_cnt==SETS_PER_EVENT-1), then acc_cnt increments.
  - An output transfer occurs when hist_vld_out && hist_rdy_in. Without a simultaneous load, hist_vld_out, sop_out and eop_out clear. With a simultaneous load, the new data replaces the old with no bubble, so full throughput is 1 set/cycle.
  - While hist_vld_out && !hist_rdy_in, hist_set_out, set_cnt_out, sop_out and eop_out are held stable.
  - Source gaps (src_vld_in[g]=0) are allowed; the event stays locked to g and the grant never changes mid-event.
  - Go to WAIT_DONE on the output transfer of the eop set.
- WAIT_DONE: all ready=0, hist_vld_out=0. On hist_done_in=1: evt_cnt_out++, pointer=g, grant_out=0, acc_cnt=0, go to IDLE. The next grant can start the cycle after.
- hist_done_in is ignored in every state other than WAIT_DONE.
- Simultaneous requests: round-robin order is strict, so the most recently served source has lowest priority.
- If the granted source drops valid, the block waits indefinitely; there is no timeout.
- Reset mid-event drops the event. No partial eop is produced, and outputs go to 0 immediately.
- SETS_PER_EVENT=1: the single set carries both sop_out=1 and eop_out=1.

Test Plan:
- Single source 0 continuously valid, hist_rdy_in=1 -> hist_clr_out pulses 1 cycle, then 54 consecutive hist_vld_out cycles with set_cnt 0..53, sop on set 0, eop on set 53. hist_done_in after 5 cycles -> evt_cnt_out=1, busy_out=0.
- Sources 0,1,2 all valid continuously -> grant order 0,1,2,0. Each event gets exactly 54 sets and one clear; evt_cnt_out=4 after the fourth done.
- Backpressure: hist_rdy_in low for 5 cycles at set 10 -> hist_set_out and set_cnt_out=10 held stable, src_rdy_out[g]=0. Resume with no lost or duplicated sets; the data pattern (set index in word 0) matches 0..53.
- Source gap: src_vld_in[g] deasserted for 3 cycles mid-event while source 3 is valid -> grant stays g, set_cnt continues contiguously, source 3 is served only after done.
- Spurious hist_done_in during STREAM -> ignored, evt_cnt_out unchanged. Reset asserted at set 20 -> all outputs 0 the same cycle; after release the next event starts from set_cnt 0 with a fresh clear.
- SETS_PER_EVENT=1 build -> each event produces one set with sop=eop=1.

Source files
------------

// File: rtl/vertex_hist_sched.sv
// Per-event round-robin scheduler that shares one vertex histogram engine
// between N_SRC track-set sources: clear, stream SETS_PER_EVENT sets, await done.
module vertex_hist_sched #(
    parameter int N_SRC          = 4,
    parameter int TRACKS_IN_SET  = 18,
    parameter int TRACK_W        = 96,
    parameter int SETS_PER_EVENT = 54,
    parameter int CNT_W          = 7
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_SRC*TRACKS_IN_SET*TRACK_W-1:0]  src_set_in,
    input  logic [N_SRC-1:0]                        src_vld_in,
    output logic [N_SRC-1:0]                        src_rdy_out,
    output logic [TRACKS_IN_SET*TRACK_W-1:0]        hist_set_out,
    output logic                                    hist_vld_out,
    input  logic                                    hist_rdy_in,
    output logic                                    hist_clr_out,
    input  logic                                    hist_done_in,
    output logic [CNT_W-1:0]                        set_cnt_out,
    output logic                                    sop_out,
    output logic                                    eop_out,
    output logic [N_SRC-1:0]                        grant_out,
    output logic [15:0]                             evt_cnt_out,
    output logic                                    busy_out
);

    localparam int                SET_W    = TRACKS_IN_SET * TRACK_W;
    localparam int                PTR_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W:0]    SETS     = (CNT_W + 1)'(SETS_PER_EVENT);
    localparam logic [CNT_W-1:0]  LAST_SET = CNT_W'(SETS_PER_EVENT - 1);

    typedef enum logic [1:0] {IDLE, CLR, STREAM, WAIT_DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   req_idx;
    logic [PTR_W-1:0]   cand;
    logic               req_any;
    logic [CNT_W-1:0]   acc_cnt;
    logic               gnt_rdy;
    logic               load;
    logic               out_xfer;
    logic               evt_done;
    logic [SET_W-1:0]   gnt_set;

    // Lowest offset from rr_ptr+1 wins, so the last served source ranks lowest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_any = 1'b0;
        req_idx = '0;
        cand    = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            cand = PTR_W'((int'(rr_ptr) + i) % N_SRC);
            if (src_vld_in[cand]) begin
                req_any = 1'b1;
                req_idx = cand;
            end
        end
    end

    assign gnt_set  = src_set_in[gnt_idx*SET_W +: SET_W];
    assign gnt_rdy  = (state == STREAM) && (!hist_vld_out || hist_rdy_in)
                      && ({1'b0, acc_cnt} < SETS);
    assign load     = gnt_rdy && src_vld_in[gnt_idx];
    assign out_xfer = hist_vld_out && hist_rdy_in;
    assign evt_done = (state == WAIT_DONE) && hist_done_in;

    always_comb begin
        src_rdy_out          = '0;
        src_rdy_out[gnt_idx] = gnt_rdy;
    end

    always_comb begin
        state_nxt    = state;
        hist_clr_out = 1'b0;
        busy_out     = (state != IDLE);
        case (state)
            IDLE:      if (req_any) state_nxt = CLR;
            CLR: begin
                hist_clr_out = 1'b1;
                state_nxt    = STREAM;
            end
            STREAM:    if (out_xfer && eop_out) state_nxt = WAIT_DONE;
            WAIT_DONE: if (hist_done_in) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= PTR_W'(N_SRC - 1);
            gnt_idx     <= '0;
            grant_out   <= '0;
            acc_cnt     <= '0;
            evt_cnt_out <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                gnt_idx   <= req_idx;
                grant_out <= N_SRC'(1) << req_idx;
            end
            if (load) acc_cnt <= acc_cnt + CNT_W'(1);
            if (evt_done) begin
                evt_cnt_out <= evt_cnt_out + 16'd1;
                rr_ptr      <= gnt_idx;
                grant_out   <= '0;
                acc_cnt     <= '0;
            end
        end
    end

    // A load alongside an output transfer simply overwrites the stage: no bubble.
    // NOTE: the wide set register is reset because every output must read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_set_out <= '0;
            hist_vld_out <= 1'b0;
            set_cnt_out  <= '0;
            sop_out      <= 1'b0;
            eop_out      <= 1'b0;
        end else if (load) begin
            hist_set_out <= gnt_set;
            hist_vld_out <= 1'b1;
            set_cnt_out  <= acc_cnt;
            sop_out      <= (acc_cnt == '0);
            eop_out      <= (acc_cnt == LAST_SET);
        end else if (out_xfer) begin
            hist_vld_out <= 1'b0;
            sop_out      <= 1'b0;
            eop_out      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vertex_hist_sched.sv
// Randomized bench for vertex_hist_sched: an event-level reference model predicts
// grants, clears, the set stream and event counts; a SETS_PER_EVENT=1 build is probed directly.
module tb_vertex_hist_sched;

    localparam int N_SRC   = 4;
    localparam int TRACKS  = 18;
    localparam int TRACK_W = 96;
    localparam int SETS    = 54;
    localparam int CNT_W   = 7;
    localparam int SET_W   = TRACKS * TRACK_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_SRC*SET_W-1:0]  src_set_in;
    logic [N_SRC-1:0]        src_vld_in, src_rdy_out, grant_out;
    logic [SET_W-1:0]        hist_set_out;
    logic                    hist_vld_out, hist_rdy_in, hist_clr_out, hist_done_in;
    logic                    sop_out, eop_out, busy_out;
    logic [CNT_W-1:0]        set_cnt_out;
    logic [15:0]             evt_cnt_out;

    logic [2*SET_W-1:0]      s1_set;
    logic [1:0]              s1_vld, s1_rdy, s1_grant;
    logic [SET_W-1:0]        s1_hset;
    logic                    s1_hvld, s1_hrdy, s1_clr, s1_done, s1_sop, s1_eop, s1_busy;
    logic [CNT_W-1:0]        s1_cnt;
    logic [15:0]             s1_evt;

    always #5 clk = ~clk;

    vertex_hist_sched #(
        .N_SRC(N_SRC), .TRACKS_IN_SET(TRACKS), .TRACK_W(TRACK_W),
        .SETS_PER_EVENT(SETS), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .src_set_in(src_set_in), .src_vld_in(src_vld_in),
        .src_rdy_out(src_rdy_out), .hist_set_out(hist_set_out), .hist_vld_out(hist_vld_out),
        .hist_rdy_in(hist_rdy_in), .hist_clr_out(hist_clr_out), .hist_done_in(hist_done_in),
        .set_cnt_out(set_cnt_out), .sop_out(sop_out), .eop_out(eop_out),
        .grant_out(grant_out), .evt_cnt_out(evt_cnt_out), .busy_out(busy_out)
    );

    vertex_hist_sched #(
        .N_SRC(2), .TRACKS_IN_SET(TRACKS), .TRACK_W(TRACK_W),
        .SETS_PER_EVENT(1), .CNT_W(CNT_W)
    ) u_dut_single (
        .clk(clk), .rst(rst), .src_set_in(s1_set), .src_vld_in(s1_vld),
        .src_rdy_out(s1_rdy), .hist_set_out(s1_hset), .hist_vld_out(s1_hvld),
        .hist_rdy_in(s1_hrdy), .hist_clr_out(s1_clr), .hist_done_in(s1_done),
        .set_cnt_out(s1_cnt), .sop_out(s1_sop), .eop_out(s1_eop),
        .grant_out(s1_grant), .evt_cnt_out(s1_evt), .busy_out(s1_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [SET_W-1:0] got,
                         input logic [SET_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (low 192 bits)", tag, got[191:0], exp[191:0]);
        end
    endtask

    // Reference model: event phases and the one-deep output stage as a queue of set indices.
    typedef enum {M_IDLE, M_CLR, M_STREAM, M_WAIT} mphase_t;
    mphase_t     ph;
    int          last, g, taken, base, evt_exp, done_wait;
    int          q[$];
    int          src_abs[N_SRC];
    logic [47:0] salt[N_SRC];

    logic [N_SRC-1:0] vld_mask;
    int  vld_pct, rdy_pct, stall_left;
    bit  stall_arm, spurious;

    function automatic logic [SET_W-1:0] make_set(int s, int abs_idx);
        logic [SET_W-1:0] v;
        v = '0;
        for (int w = 0; w < TRACKS; w++)
            v[w*TRACK_W +: TRACK_W] = {salt[s], 8'(w), 8'(s), 32'(abs_idx)};
        return v;
    endfunction

    function automatic int rr_pick(int from, logic [N_SRC-1:0] v);
        for (int i = 1; i <= N_SRC; i++)
            if (v[(from + i) % N_SRC]) return (from + i) % N_SRC;
        return -1;
    endfunction

    task automatic drive_sets();
        for (int s = 0; s < N_SRC; s++)
            src_set_in[s*SET_W +: SET_W] = make_set(s, src_abs[s]);
    endtask

    task automatic drive_stim();
        for (int s = 0; s < N_SRC; s++)
            src_vld_in[s] = vld_mask[s] && ($urandom_range(0, 99) < vld_pct);
        if (stall_arm && ph == M_STREAM && q.size() > 0 && q[0] == 10) begin
            stall_left = 5;
            stall_arm  = 1'b0;
        end
        hist_rdy_in = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        if (stall_left > 0) stall_left--;
        hist_done_in = 1'b0;
        if (ph == M_WAIT) begin
            if (done_wait == 0) hist_done_in = 1'b1;
            else done_wait--;
        end else if (ph == M_STREAM && spurious && $urandom_range(0, 15) == 0) begin
            hist_done_in = 1'b1;
        end
        drive_sets();
    endtask

    task automatic model_reset();
        ph = M_IDLE; last = N_SRC - 1; g = 0; taken = 0; base = 0;
        evt_exp = 0; done_wait = 0; stall_left = 0;
        q.delete();
    endtask

    task automatic step();
        logic [N_SRC-1:0] exp_rdy, exp_gnt;
        bit  fire, xfer, was_eop, done_now;
        int  pick, k;
        @(negedge clk);
        exp_gnt = (ph == M_IDLE) ? '0 : (N_SRC'(1) << g);
        exp_rdy = '0;
        if (ph == M_STREAM && (q.size() == 0 || hist_rdy_in) && taken < SETS) exp_rdy[g] = 1'b1;
        check("evt_cnt", evt_cnt_out, evt_exp);
        check("busy", busy_out, ph != M_IDLE);
        check("clr", hist_clr_out, ph == M_CLR);
        check("grant", grant_out, exp_gnt);
        check("hist_vld", hist_vld_out, q.size() > 0);
        check("src_rdy", src_rdy_out, exp_rdy);
        if (q.size() > 0) begin
            k = q[0];
            check("set_cnt", set_cnt_out, k);
            check("sop", sop_out, k == 0);
            check("eop", eop_out, k == SETS - 1);
            check("set_data", hist_set_out, make_set(g, base + k));
        end
        fire     = |(exp_rdy & src_vld_in);
        xfer     = (q.size() > 0) && hist_rdy_in;
        was_eop  = xfer && (q[0] == SETS - 1);
        done_now = (ph == M_WAIT) && hist_done_in;
        pick     = (ph == M_IDLE) ? rr_pick(last, src_vld_in) : -1;
        @(posedge clk);
        #1;
        case (ph)
            M_IDLE: if (pick >= 0) begin
                g = pick; ph = M_CLR; base = src_abs[pick]; taken = 0;
            end
            M_CLR: ph = M_STREAM;
            M_STREAM: begin
                if (xfer) void'(q.pop_front());
                if (fire) begin
                    q.push_back(taken);
                    taken++;
                    src_abs[g]++;
                end
                if (was_eop) begin
                    ph = M_WAIT;
                    done_wait = $urandom_range(0, 5);
                end
            end
            M_WAIT: if (done_now) begin
                evt_exp = (evt_exp + 1) % 65536;
                last = g;
                ph = M_IDLE;
            end
            default: ph = M_IDLE;
        endcase
        drive_stim();
    endtask

    task automatic run_until_evt(input int target, input int max_cyc);
        int n;
        n = 0;
        while (evt_exp != target && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            salt[s]    = {16'($urandom), 32'($urandom)};
            src_abs[s] = 0;
        end
        src_vld_in = '0; hist_rdy_in = 1'b0; hist_done_in = 1'b0;
        s1_vld = '0; s1_hrdy = 1'b1; s1_done = 1'b0;
        s1_set = {make_set(1, 0), make_set(0, 0)};
        drive_sets();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {hist_vld_out, hist_clr_out, sop_out, eop_out, busy_out,
                            grant_out, src_rdy_out, set_cnt_out, evt_cnt_out}, '0);
        check("reset_data", hist_set_out, '0);

        // Single source, no backpressure except a 5-cycle stall while set 10 is presented.
        vld_mask = 4'b0001; vld_pct = 100; rdy_pct = 100; stall_arm = 1'b1; spurious = 1'b0;
        rst = 1'b0;
        drive_stim();
        run_until_evt(1, 400);

        // Three continuously valid sources: strict round-robin order.
        vld_mask = 4'b0111;
        run_until_evt(5, 1200);

        // All sources with random gaps, backpressure and spurious done pulses.
        vld_mask = 4'b1111; vld_pct = 80; rdy_pct = 75; spurious = 1'b1;
        run_until_evt(9, 3000);

        // Reset in the middle of an event once set 20 has been taken.
        n = 0;
        while (!(ph == M_STREAM && taken >= 20) && n < 1000) begin
            step();
            n++;
        end
        rst = 1'b1;
        #1;
        check("midrst_ctl", {hist_vld_out, hist_clr_out, sop_out, eop_out, busy_out,
                             grant_out, src_rdy_out, set_cnt_out, evt_cnt_out}, '0);
        check("midrst_data", hist_set_out, '0);
        model_reset();
        hist_done_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        drive_stim();
        run_until_evt(3, 1500);

        // SETS_PER_EVENT=1 build: every event is a single set with sop and eop.
        src_vld_in = '0;
        s1_vld = 2'b11;
        for (int e = 0; e < 3; e++) begin
            n = 0;
            @(negedge clk);
            while (!s1_hvld && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("s1_vld", s1_hvld, 1'b1);
            check("s1_sop", s1_sop, 1'b1);
            check("s1_eop", s1_eop, 1'b1);
            check("s1_cnt", s1_cnt, 0);
            check("s1_grant", s1_grant, (e % 2 == 0) ? 2'b01 : 2'b10);
            check("s1_data", s1_hset, make_set(e % 2, 0));
            @(posedge clk);
            @(posedge clk);
            #1 s1_done = 1'b1;
            @(posedge clk);
            #1 s1_done = 1'b0;
            @(negedge clk);
            check("s1_evt", s1_evt, e + 1);
            check("s1_busy", s1_busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
